instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instr_fetch_if.sv | 33 +++
 rtl/pc_reg.sv | 45 ++++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch block: default widths, the
// PC start address, the fetch FSM state enum and a saturating counter helper.
// Optional feature macro used by instr_fetch: INSTR_FETCH_CYCLE_CNT_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int INSTR_W_DEF    = 9;
   localparam int START_ADDR_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam logic [15:0] CYC_MAX = 16'hFFFF;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == CYC_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the controller handshake and instruction-ROM bus of instr_fetch.
//   master : controller/ROM side - drives start, stall, branch_taken,
//            branch_target, halt, imem_rdata; observes the fetch outputs.
//   slave  : the fetch unit - drives imem_addr, instr, instr_valid, pc, done.
// -----------------------------------------------------------------------------
interface instr_fetch_if import fetch_pkg::*; #(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
);
   logic               start;
   logic               stall;
   logic               branch_taken;
   logic [ADDR_W-1:0]  branch_target;
   logic               halt;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [ADDR_W-1:0]  pc;
   logic               done;

   modport master (
      output start, stall, branch_taken, branch_target, halt, imem_rdata,
      input  imem_addr, instr, instr_valid, pc, done
   );

   modport slave (
      input  start, stall, branch_taken, branch_target, halt, imem_rdata,
      output imem_addr, instr, instr_valid, pc, done
   );
endinterface

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program-counter register with load / increment / hold.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pc -> START_ADDR)
//   load_i     in   load load_val_i (has priority over inc_i)
//   load_val_i in   value to load
//   inc_i      in   pc <= pc + 1, wrapping modulo 2^ADDR_W
//   pc_o       out  current pc
// -----------------------------------------------------------------------------
module pc_reg import fetch_pkg::*; #(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int START_ADDR = START_ADDR_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);
   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= START_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: walks the program counter through an instruction
// ROM and registers each instruction for the controller, with stall, branch
// redirect and halt.
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   bus          slave modport of instr_fetch_if (handshake + ROM bus)
//   cycle_count  out  16-bit saturating count of FETCH cycles; present only
//                     when INSTR_FETCH_CYCLE_CNT_EN is defined
// -----------------------------------------------------------------------------
module instr_fetch import fetch_pkg::*; #(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int INSTR_W    = INSTR_W_DEF,
   parameter int START_ADDR = START_ADDR_DEF
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_if.slave       bus
`ifdef INSTR_FETCH_CYCLE_CNT_EN
   ,
   output logic [15:0]        cycle_count
`endif
);
   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

   fetch_state_e       state_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;
   logic               done_q;
   logic [ADDR_W-1:0]  pc;

   // start only counts outside FETCH; a fetch happens only when neither
   // halt (highest priority) nor stall blocks it.
   logic start_acc;
   logic fetch_go;
   assign start_acc = bus.start && (state_q != ST_FETCH);
   assign fetch_go  = (state_q == ST_FETCH) && !bus.halt && !bus.stall;

   pc_reg #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR)
   ) u_pc_reg (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (start_acc || (fetch_go && bus.branch_taken)),
      .load_val_i (start_acc ? START_PC : bus.branch_target),
      .inc_i      (fetch_go && !bus.branch_taken),
      .pc_o       (pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (bus.halt) begin
                  state_q <= ST_HALTED;
                  done_q  <= 1'b1;
                  valid_q <= 1'b0;
               end else if (!bus.stall) begin
                  instr_q <= bus.imem_rdata;
                  valid_q <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (bus.start) begin
                  state_q <= ST_FETCH;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef INSTR_FETCH_CYCLE_CNT_EN
   logic [15:0] cyc_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
      end else if (start_acc) begin
         cyc_q <= '0;
      end else if (state_q == ST_FETCH) begin
         cyc_q <= sat_inc16(cyc_q);
      end
   end
   assign cycle_count = cyc_q;
`endif

   assign bus.imem_addr   = pc;
   assign bus.pc          = pc;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run against a behavioural program-counter model. Build with
// INSTR_FETCH_CYCLE_CNT_EN defined to also check cycle_count.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
   import fetch_pkg::*;

   localparam int AW    = 10;
   localparam int IW    = 9;
   localparam int START = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
`ifdef INSTR_FETCH_CYCLE_CNT_EN
   logic [15:0] cycle_count;
`endif

   instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .START_ADDR(START)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus)
`ifdef INSTR_FETCH_CYCLE_CNT_EN
      ,
      .cycle_count (cycle_count)
`endif
   );

   logic [IW-1:0] rom [1024];
   assign bus.imem_rdata = rom[bus.imem_addr];

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: "running" / "halted" flags and plain arithmetic.
   bit            m_run, m_halt, m_valid, m_done;
   logic [AW-1:0] m_pc;
   logic [IW-1:0] m_instr;
   int            m_cnt;

   task automatic model_clear();
      m_run = 0; m_halt = 0; m_valid = 0; m_done = 0;
      m_pc = AW'(START); m_instr = '0; m_cnt = 0;
   endtask

   task automatic drive_idle();
      bus.start = 0; bus.stall = 0; bus.branch_taken = 0;
      bus.branch_target = '0; bus.halt = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      drive_idle();
      reset = 0;
      model_clear();
      @(negedge clk);
      reset = 1;
   endtask

   // One clock of stimulus; the model advances on the same edge.
   task automatic step(input bit st, input bit sl, input bit br,
                       input logic [AW-1:0] tg, input bit hl);
      @(negedge clk);
      bus.start = st; bus.stall = sl; bus.branch_taken = br;
      bus.branch_target = tg; bus.halt = hl;
      @(posedge clk);
      if (!m_run && !m_halt) begin
         if (st) begin m_run = 1; m_pc = AW'(START); m_cnt = 0; end
      end else if (m_halt) begin
         if (st) begin m_halt = 0; m_run = 1; m_done = 0; m_pc = AW'(START); m_cnt = 0; end
      end else begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (hl) begin
            m_run = 0; m_halt = 1; m_done = 1; m_valid = 0;
         end else if (!sl) begin
            m_instr = rom[m_pc];
            m_valid = 1;
            m_pc = br ? tg : AW'((int'(m_pc) + 1) % 1024);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 0;
      model_clear();
      repeat (2) @(negedge clk);
      n_tests++; if (bus.pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 10'h000); end
      n_tests++; if (bus.instr !== 9'h000) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", bus.instr, 9'h000); end
      n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      reset = 1;
      // No start: must stay idle.
      repeat (3) step(0, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'h000 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got pc %h valid %b expected pc 000 valid 0", bus.pc, bus.instr_valid); end
   endtask

   task automatic test_sequence();
      logic [IW-1:0] exp_i [4];
      exp_i = '{9'h011, 9'h022, 9'h033, 9'h044};
      reset_dut();
      step(1, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'd0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_start: got pc %h valid %b expected pc 000 valid 0", bus.pc, bus.instr_valid); end
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 0, '0, 0);
         n_tests++; if (bus.instr !== exp_i[k-1] || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_instr%0d: got %h/%b expected %h/1", k, bus.instr, bus.instr_valid, exp_i[k-1]); end
         n_tests++; if (bus.pc !== AW'(k)) begin n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", k, bus.pc, AW'(k)); end
      end
   endtask

   task automatic test_stall();
      reset_dut();
      step(1, 0, 0, '0, 0);
      repeat (2) step(0, 0, 0, '0, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 1, 10'h155, 0);
         n_tests++; if (bus.pc !== 10'd2 || bus.instr !== 9'h022) begin n_fail++; $display("FAIL stall%0d: got pc %h instr %h expected pc 002 instr 022", k, bus.pc, bus.instr); end
      end
      step(0, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'd3 || bus.instr !== 9'h033) begin n_fail++; $display("FAIL stall_resume: got pc %h instr %h expected pc 003 instr 033", bus.pc, bus.instr); end
   endtask

   task automatic test_branch_halt();
      reset_dut();
      step(1, 0, 0, '0, 0);
      repeat (5) step(0, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'd5) begin n_fail++; $display("FAIL br_pre: got %h expected %h", bus.pc, 10'd5); end
      step(0, 0, 1, 10'h100, 0);
      n_tests++; if (bus.pc !== 10'h100 || bus.instr !== rom[5]) begin n_fail++; $display("FAIL branch: got pc %h instr %h expected pc 100 instr %h", bus.pc, bus.instr, rom[5]); end
      step(0, 1, 1, 10'h2AA, 0);
      n_tests++; if (bus.pc !== 10'h100) begin n_fail++; $display("FAIL branch_stalled: got %h expected %h", bus.pc, 10'h100); end
      // start during FETCH must be ignored
      step(1, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'h101) begin n_fail++; $display("FAIL start_in_fetch: got %h expected %h", bus.pc, 10'h101); end
      step(0, 1, 1, 10'h0AA, 1);
      n_tests++; if (bus.done !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== 10'h101) begin n_fail++; $display("FAIL halt: got done %b valid %b pc %h expected 1 0 101", bus.done, bus.instr_valid, bus.pc); end
      repeat (2) step(0, 0, 1, 10'h0AA, 0);
      n_tests++; if (bus.done !== 1'b1 || bus.pc !== 10'h101) begin n_fail++; $display("FAIL halted_hold: got done %b pc %h expected 1 101", bus.done, bus.pc); end
      step(1, 0, 0, '0, 0);
      n_tests++; if (bus.done !== 1'b0 || bus.pc !== 10'd0) begin n_fail++; $display("FAIL restart: got done %b pc %h expected 0 000", bus.done, bus.pc); end
      step(0, 0, 0, '0, 0);
      n_tests++; if (bus.instr !== rom[0] || bus.pc !== 10'd1) begin n_fail++; $display("FAIL restart_fetch: got instr %h pc %h expected %h 001", bus.instr, bus.pc, rom[0]); end
   endtask

   task automatic test_wrap_reset();
      step(0, 0, 1, 10'h3FF, 0);
      n_tests++; if (bus.pc !== 10'h3FF) begin n_fail++; $display("FAIL wrap_pre: got %h expected %h", bus.pc, 10'h3FF); end
      step(0, 0, 0, '0, 0);
      n_tests++; if (bus.pc !== 10'h000 || bus.instr !== rom[1023]) begin n_fail++; $display("FAIL wrap: got pc %h instr %h expected 000 %h", bus.pc, bus.instr, rom[1023]); end
      step(0, 0, 0, '0, 0);
      // asynchronous reset in the middle of a cycle
      #2 reset = 0;
      model_clear();
      #1;
      n_tests++; if (bus.pc !== 10'h000 || bus.instr_valid !== 1'b0 || bus.instr !== 9'h000) begin n_fail++; $display("FAIL async_reset: got pc %h valid %b instr %h expected 000 0 000", bus.pc, bus.instr_valid, bus.instr); end
      @(negedge clk);
      reset = 1;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, '0, 0);
         n_tests++; if (bus.pc !== 10'h000 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset%0d: got pc %h valid %b expected 000 0", k, bus.pc, bus.instr_valid); end
      end
   endtask

   task automatic test_random();
      reset_dut();
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), AW'($urandom), ($urandom_range(0, 39) == 0));
         n_tests++; if (bus.pc !== m_pc || bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got pc %h addr %h expected %h", k, bus.pc, bus.imem_addr, m_pc); end
         n_tests++; if (bus.instr_valid !== m_valid || (m_valid && bus.instr !== m_instr)) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h/%b expected %h/%b", k, bus.instr, bus.instr_valid, m_instr, m_valid); end
         n_tests++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rnd_done@%0d: got %b expected %b", k, bus.done, m_done); end
`ifdef INSTR_FETCH_CYCLE_CNT_EN
         n_tests++; if (cycle_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cyc@%0d: got %0d expected %0d", k, cycle_count, m_cnt); end
`endif
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = IW'($urandom);
      rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044;
      test_reset();
      test_sequence();
      test_stall();
      test_branch_halt();
      test_wrap_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
